priority_extractor: RTL
=======================

Name: priority_extractor

Overview:
Successor to the single-shot priority encoder. It accepts a WIDTH-bit word and emits every set bit as its own one-hot beat, together with that bit's index. The scan direction is selectable per word: MSB-first or LSB-first. The output uses a valid/ready handshake, and the last beat of a word is flagged. It sits between request-mask producers and serial consumers such as schedulers and interrupt dispatch.

Parameters:
WIDTH, 7, width of the input word and of the one-hot output (WIDTH >= 2)
IDX_W, $clog2(WIDTH), width of the index output (derived; not overridden)

Ports:
clk_i  in  1  clock; all logic on the rising edge
srst_i  in  1  synchronous reset, active-high
data_i  in  WIDTH  input word
data_val_i  in  1  input word valid
dir_i  in  1  scan direction, sampled with the word: 1 = MSB-first, 0 = LSB-first
data_ready_o  out  1  block can accept a word
data_o  out  WIDTH  one-hot current bit
data_idx_o  out  IDX_W  index of the set bit in data_o
data_last_o  out  1  current beat is the final set bit of the word
data_val_o  out  1  output beat valid
data_ready_i  in  1  downstream accepts the beat

Behaviour:
- One clock, clk_i. Reset srst_i is synchronous and active-high.
- Two states:
  - IDLE: data_ready_o = 1.
  - BUSY: data_ready_o = 0.
  - data_ready_o is decoded from the state register only, with no combinational path from any input.
- Reset takes priority over everything, including mid-word reset. It forces:
  - state = IDLE;
  - remaining-mask register = 0;
  - data_o = 0, data_idx_o = 0, data_last_o = 0, data_val_o = 0;
  - data_ready_o = 1 in the cycle after reset.
  - Any partially emitted word is discarded.
- Accept: data_val_i & data_ready_o at edge N.
  - Word is nonzero:
    - dir_i is latched for the whole word.
    - Outputs registered at edge N give the first set bit in the latched direction: data_val_o = 1 from cycle N+1 (latency 1).
    - remaining = data_i & ~data_o.
    - data_last_o = (remaining == 0).
    - state goes to BUSY.
  - Word is zero: it is dropped. No beat is produced and the state stays IDLE.
- data_val_i while data_ready_o = 0 is ignored. There is no buffering and no error flag.
- Beat transfer: data_val_o & data_ready_i at an edge.
  - data_last_o = 1: data_val_o = 0, data_last_o = 0, data_o = 0, state goes to IDLE. The next word can be accepted the cycle after.
  - Otherwise, the next set bit of remaining in the latched direction is loaded into data_o/data_idx_o, remaining clears that bit, and data_last_o is recomputed.
- Throughput is one beat per cycle while data_ready_i = 1.
- Backpressure: while data_val_o = 1 and data_ready_i = 0, data_o, data_idx_o and data_last_o hold stable.
- data_idx_o always equals the binary position of the single 1 in data_o. It is 0 when data_val_o = 0.
- A word with k set bits yields exactly k beats in strictly monotonic index order: descending for MSB-first, ascending for LSB-first. The OR of all its beats equals the input word.
- An input change or dir_i change during BUSY has no effect on the word in flight.

Test Plan:
- WIDTH=7, data_i=7'b1010010, dir_i=1, data_ready_i=1 → beats 7'b1000000/idx 6, 7'b0010000/idx 4, 7'b0000010/idx 1 with last=1 on the third. data_ready_o returns to 1 the cycle after the third beat.
- Same word, dir_i=0 → beats idx 1, 4, 6 with last on idx 6.
- data_i=7'b0000000 with data_val_i=1 → no data_val_o, data_ready_o stays 1. Then 7'b1111111 with dir_i=0 → 7 consecutive beats idx 0..6, last only on idx 6.
- 7'b0100100 MSB-first, data_ready_i low for 3 cycles on the first beat → data_o=7'b0100000/idx 5 held for 4 cycles, then 7'b0000100/idx 2 last. A new data_val_i during BUSY with 7'b0000001 → ignored.
- srst_i asserted one cycle after the second beat of 7'b1111111 → next cycle all outputs 0, data_ready_o=1. A fresh 7'b0001000 → single beat idx 3, last=1.
- Random words and directions against a reference model: beat count = popcount, OR of beats = word, monotonic index order, stability under random data_ready_i.

Source files
------------

// File: rtl/priority_extractor.sv
// Priority extractor: accepts a word and emits each set bit as a one-hot beat with its index,
// MSB-first or LSB-first per word, over a valid/ready output handshake.
module priority_extractor #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_val_i,
   input  logic             dir_i,
   output logic             data_ready_o,
   output logic [WIDTH-1:0] data_o,
   output logic [IDX_W-1:0] data_idx_o,
   output logic             data_last_o,
   output logic             data_val_o,
   input  logic             data_ready_i
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             last_q, last_d;
   logic             val_q, val_d;
   logic             dir_q, dir_d;

   logic [WIDTH-1:0] src;
   logic             pick_dir;
   logic [IDX_W-1:0] pick_idx;
   logic [WIDTH-1:0] pick_oh;
   logic [WIDTH-1:0] pick_rem;

   // In IDLE the candidate is the incoming word; in BUSY it is the remaining mask.
   always_comb begin
      src      = (state_q == ST_IDLE) ? data_i : rem_q;
      pick_dir = (state_q == ST_IDLE) ? dir_i  : dir_q;
      pick_idx = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (pick_dir) begin
            if (src[i]) pick_idx = IDX_W'(i);
         end else begin
            if (src[WIDTH-1-i]) pick_idx = IDX_W'(WIDTH-1-i);
         end
      end
      pick_oh  = (|src) ? (WIDTH'(1) << pick_idx) : '0;
      pick_rem = src & ~pick_oh;
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      data_d  = data_q;
      idx_d   = idx_q;
      last_d  = last_q;
      val_d   = val_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (data_val_i && (|data_i)) begin
               state_d = ST_BUSY;
               dir_d   = dir_i;
               data_d  = pick_oh;
               idx_d   = pick_idx;
               rem_d   = pick_rem;
               last_d  = (pick_rem == '0);
               val_d   = 1'b1;
            end
         end
         ST_BUSY: begin
            if (data_ready_i) begin
               if (last_q) begin
                  state_d = ST_IDLE;
                  data_d  = '0;
                  idx_d   = '0;
                  rem_d   = '0;
                  last_d  = 1'b0;
                  val_d   = 1'b0;
               end else begin
                  data_d  = pick_oh;
                  idx_d   = pick_idx;
                  rem_d   = pick_rem;
                  last_d  = (pick_rem == '0);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         val_q   <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         val_q   <= val_d;
         dir_q   <= dir_d;
      end
   end

   assign data_ready_o = (state_q == ST_IDLE);
   assign data_o       = data_q;
   assign data_idx_o   = idx_q;
   assign data_last_o  = last_q;
   assign data_val_o   = val_q;

endmodule
